// File: rtl/mux_pkg.sv
// Shared constants and width helpers for the round-robin stream multiplexer.
package mux_pkg;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_DATA_W = 32;

    function automatic int clog2(input int value);
        int r = 0;
        int v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr,
// wrapping to the lowest requester when none is found above.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int SEL_W  = sel_width(DEFAULT_NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any_grant
);

    logic [NUM_CH-1:0] hi_mask;
    logic [NUM_CH-1:0] pick;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
        assign hi_mask[gi] = (SEL_W'(gi) >= ptr);
    end

    // Prefer requesters at or above ptr; fall back to the full set for the wrap.
    always_comb begin
        pick = '0;
        if (enable) begin
            pick = (|(req & hi_mask)) ? (req & hi_mask) : req;
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = |pick;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration and one output register.
// Optional packet lock (no interleaving until in_last) enabled by RR_STREAM_MUX_PKT_LOCK_EN.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int  NUM_CH = DEFAULT_NUM_CH,
    parameter int  DATA_W = DEFAULT_DATA_W,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_last,
`endif
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  ptr_reg;
    logic [SEL_W-1:0]  ptr_next;
    logic [SEL_W-1:0]  grant_idx;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic              any_grant;
    logic              load_en;
    logic [DATA_W-1:0] sel_data;

    assign load_en = !out_valid || out_ready;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    logic              locked_reg;
    logic [SEL_W-1:0]  lock_ch_reg;
    logic [NUM_CH-1:0] lock_mask;
    logic              grant_last;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lock_mask
        assign lock_mask[gi] = (lock_ch_reg == SEL_W'(gi));
    end

    // While a packet is open only its owner may request, even if it is idle.
    assign req        = locked_reg ? (in_valid & lock_mask) : in_valid;
    assign grant_last = |(grant & in_last);
`else
    assign req = in_valid;
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_reg),
        .enable    (load_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign in_ready = grant;
    assign ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    // Grant is one-hot, so an AND-OR select avoids indexing past NUM_CH.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel     <= '0;
            ptr_reg     <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            out_last    <= 1'b0;
            locked_reg  <= 1'b0;
            lock_ch_reg <= '0;
`endif
        end else if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            out_last  <= grant_last;
            if (grant_last) begin
                ptr_reg    <= ptr_next;
                locked_reg <= 1'b0;
            end else begin
                locked_reg  <= 1'b1;
                lock_ch_reg <= grant_idx;
            end
`else
            ptr_reg   <= ptr_next;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: 4-channel and 3-channel instances side by side.
// Packet-lock scenario runs only when RR_STREAM_MUX_PKT_LOCK_EN is defined.
module tb_rr_stream_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [3:0]   in_valid  = '0;
    logic [127:0] in_data   = '0;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready = 1'b0;

    logic [2:0]   in_valid3  = '0;
    logic [95:0]  in_data3   = '0;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_ready3 = 1'b0;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    logic [3:0]   in_last  = '1;
    logic         out_last;
    logic [2:0]   in_last3 = '1;
    logic         out_last3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_stream_mux #(.NUM_CH(4), .DATA_W(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    rr_stream_mux #(.NUM_CH(3), .DATA_W(32)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        .in_last   (in_last3),
        .out_last  (out_last3),
`endif
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
    );

    function automatic logic [31:0] pay(input int k);
        return 32'hD000_0000 + 32'(k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_payloads();
        for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = pay(k);
        for (int k = 0; k < 3; k++) in_data3[k*32 +: 32] = pay(k) + 32'h0100;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        in_valid3 = '0;
        out_ready = 1'b0;
        out_ready3 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_checks++; if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
        step();
        rst = 1'b0;
        // Load a beat from ch2 and stall it.
        in_data[2*32 +: 32] = 32'hAAAA_0001;
        in_valid = 4'b0100;
        out_ready = 1'b0;
        #1;
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL reset_pre_ready: got %b want 0100", in_ready); end
        step();
        $display("reset_stall: beat loaded valid=%b sel=%0d data=%h", out_valid, out_sel, out_data);
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'hAAAA_0001) begin
            n_fail++; $display("FAIL stall_beat: got v=%b sel=%0d data=%h want v=1 sel=2 data=aaaa0001", out_valid, out_sel, out_data); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready: got %b want 0000", in_ready); end
        // Mid-cycle reset must clear the held beat without waiting for a clock edge.
        #1 rst = 1'b1;
        #1;
        $display("reset_async: valid=%b sel=%0d data=%h", out_valid, out_sel, out_data);
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: got v=%b sel=%0d data=%h want all zero", out_valid, out_sel, out_data); end
        #1 rst = 1'b0;
        load_payloads();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL post_reset_ready: got %b want 0001", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== pay(0)) begin
            n_fail++; $display("FAIL post_reset_grant: got v=%b sel=%0d data=%h want v=1 sel=0 data=%h", out_valid, out_sel, out_data, pay(0)); end
    endtask

    task automatic test_round_robin();
        do_reset();
        load_payloads();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (in_ready !== 4'(1 << (i % 4))) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << (i % 4))); end
            step();
            $display("rr beat %0d: sel=%0d data=%h", i, out_sel, out_data);
            n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== pay(i % 4)) begin
                n_fail++; $display("FAIL rr_beat[%0d]: got v=%b sel=%0d data=%h want sel=%0d data=%h", i, out_valid, out_sel, out_data, i % 4, pay(i % 4)); end
        end
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        load_payloads();
        out_ready = 1'b1;
        in_valid = 4'b0100;
        step();                              // ch2 granted, pointer moves to 3
        in_valid = 4'b0101;
        step();
        $display("sparse beat 0: sel=%0d data=%h", out_sel, out_data);
        n_checks++; if (out_sel !== 2'd0 || out_data !== pay(0)) begin
            n_fail++; $display("FAIL sparse_wrap: got sel=%0d data=%h want sel=0 data=%h", out_sel, out_data, pay(0)); end
        step();
        $display("sparse beat 1: sel=%0d data=%h", out_sel, out_data);
        n_checks++; if (out_sel !== 2'd2 || out_data !== pay(2)) begin
            n_fail++; $display("FAIL sparse_next: got sel=%0d data=%h want sel=2 data=%h", out_sel, out_data, pay(2)); end
        in_valid = 4'b0000;
        step();
        $display("drain: valid=%b sel=%0d data=%h", out_valid, out_sel, out_data);
        n_checks++; if (out_valid !== 1'b0 || out_sel !== 2'd2 || out_data !== pay(2)) begin
            n_fail++; $display("FAIL drain: got v=%b sel=%0d data=%h want v=0 sel=2 data=%h", out_valid, out_sel, out_data, pay(2)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_payloads();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        step();
        step();                              // ch1 held, pointer at 2
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready); end
            step();
            $display("stall cycle %0d: sel=%0d data=%h", i, out_sel, out_data);
            n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== pay(1)) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h want v=1 sel=1 data=%h", i, out_valid, out_sel, out_data, pay(1)); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
        step();
        n_checks++; if (out_sel !== 2'd2 || out_data !== pay(2)) begin
            n_fail++; $display("FAIL bp_release: got sel=%0d data=%h want sel=2 data=%h", out_sel, out_data, pay(2)); end
    endtask

    task automatic test_num_ch3();
        do_reset();
        load_payloads();
        in_valid3 = 3'b111;
        out_ready3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            $display("ch3 beat %0d: sel=%0d data=%h", i, out_sel3, out_data3);
            n_checks++; if (out_valid3 !== 1'b1 || out_sel3 !== 2'(i % 3) || out_data3 !== pay(i % 3) + 32'h0100) begin
                n_fail++; $display("FAIL ch3_beat[%0d]: got v=%b sel=%0d data=%h want sel=%0d", i, out_valid3, out_sel3, out_data3, i % 3); end
        end
    endtask

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        do_reset();
        load_payloads();
        out_ready = 1'b1;
        in_last = 4'b1111;
        in_valid = 4'b0001;
        step();                              // ch0 single beat, pointer at 1
        in_valid = 4'b0111;
        in_last = 4'b0000;
        for (int b = 0; b < 3; b++) begin
            in_data[1*32 +: 32] = 32'hB100_0000 + 32'(b);
            in_last = (b == 2) ? 4'b0010 : 4'b0000;
            #1;
            n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_ready[%0d]: got %b want 0010", b, in_ready); end
            step();
            $display("lock beat %0d: sel=%0d data=%h last=%b", b, out_sel, out_data, out_last);
            n_checks++; if (out_sel !== 2'd1 || out_data !== 32'hB100_0000 + 32'(b) || out_last !== (b == 2)) begin
                n_fail++; $display("FAIL lock_beat[%0d]: got sel=%0d data=%h last=%b want sel=1 last=%b", b, out_sel, out_data, out_last, b == 2); end
        end
        in_last = 4'b1111;
        step();
        n_checks++; if (out_sel !== 2'd2 || out_data !== pay(2) || out_last !== 1'b1) begin
            n_fail++; $display("FAIL lock_after: got sel=%0d data=%h last=%b want sel=2 data=%h last=1", out_sel, out_data, out_last, pay(2)); end
    endtask
`endif

    initial begin
        load_payloads();
        test_reset();
        test_round_robin();
        test_sparse_wrap();
        test_backpressure();
        test_num_ch3();
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
